// File: rtl/mux_pipe_reg.sv
// N-to-1 channel select feeding a registered output stage with a one-entry skid buffer.
// Optional flush support is compiled in with the MUX_PIPE_FLUSH_EN macro.
module mux_pipe_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      NUM_IN    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush
);

    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             accept;
    logic             xfer;
    logic             flush_act;

`ifdef MUX_PIPE_FLUSH_EN
    assign flush_act = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_act    = 1'b0;
`endif

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        sel_word = in_data[WIDTH-1:0];
        for (int unsigned k = 1; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = in_valid && !skid_valid_q;
    assign xfer   = main_valid_q && out_ready;

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (flush_act) begin
            main_data_d  = RESET_VAL;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (xfer) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || xfer) begin
                main_data_d  = sel_word;
                main_valid_d = 1'b1;
            end else begin
                // Main is stalled: park the new beat so in_ready can stay registered.
                skid_data_d  = sel_word;
                skid_valid_d = 1'b1;
            end
        end else if (xfer) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_data_q  <= RESET_VAL;
            main_valid_q <= 1'b0;
            skid_data_q  <= RESET_VAL;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_data  = main_data_q;
    assign out_valid = main_valid_q;

endmodule
